// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source selects, fetch FSM encoding and instruction field positions.
package cpu_pkg;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10,
    S_HALT  = 2'b11
  } fetchState_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int JT_MSB = 25;
  localparam int JT_LSB = 0;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection: sequential, PC-relative branch, or pseudo-direct jump (all modulo 2^32).
module next_pc_gen
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] ExtImm,
  input  logic [25:0] instrTarget,
  input  logic [1:0]  PCSrc,
  output logic [31:0] next_pc
);

  // Reserved select 11 falls through to sequential flow
  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      PC_NEXT:   next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + (ExtImm << 2'd2);
      PC_JUMP:   next_pc = {pc_plus4[31:28], instrTarget, 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack handshake, instruction register and halt latch.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        halted
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetchState_t state_r, nextState_s;
  logic [31:0] pc_r, instr_r, nextPc_s;
  logic        req_r, valid_r, halted_r;
  logic        instrLoad_s, pcLoad_s, retire_s;

  assign pc_plus4    = pc_r + 32'd4;
  assign pc          = pc_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign imem_req    = req_r;
  assign instr_valid = valid_r;
  assign halted      = halted_r;

  next_pc_gen u_next_pc_gen (
    .pc_plus4    (pc_plus4),
    .ExtImm      (ExtImm),
    .instrTarget (instr_r[JT_MSB:JT_LSB]),
    .PCSrc       (PCSrc),
    .next_pc     (nextPc_s)
  );

  // Next-state and datapath load enables; halt wins over any PCSrc at the handshake
  always_comb begin
    nextState_s = state_r;
    instrLoad_s = 1'b0;
    pcLoad_s    = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        nextState_s = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instrLoad_s = 1'b1;
          nextState_s = S_ISSUE;
        end else begin
          nextState_s = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          retire_s = 1'b1;
          if (PCWre) begin
            pcLoad_s    = 1'b1;
            nextState_s = S_FETCH;
          end else begin
            nextState_s = S_HALT;
          end
        end else begin
          nextState_s = S_ISSUE;
        end
      end
      S_HALT: begin
        nextState_s = S_HALT;
      end
      default: begin
        nextState_s = S_IDLE;
      end
    endcase
  end

  // State, PC, instruction register and registered status outputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC_ALIGNED;
      instr_r  <= 32'h0000_0000;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= nextState_s;
      req_r    <= (nextState_s == S_FETCH);
      valid_r  <= (nextState_s == S_ISSUE);
      halted_r <= (nextState_s == S_HALT);
      if (instrLoad_s) begin
        instr_r <= imem_rdata;
      end
      if (pcLoad_s) begin
        pc_r <= nextPc_s;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_r, stall_r;
  assign retired_cnt = retired_r;
  assign stall_cnt   = stall_r;

  // Retired instructions (halt included) and FETCH cycles spent waiting on memory
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      retired_r <= 32'h0000_0000;
      stall_r   <= 32'h0000_0000;
    end else begin
      if (retire_s) begin
        retired_r <= retired_r + 32'd1;
      end
      if ((state_r == S_FETCH) && !imem_ack) begin
        stall_r <= stall_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven program walk plus reset/halt sequences.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ExtImm = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .ExtImm(ExtImm),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4),
`ifdef FETCH_PERF_CNT_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    int          readyDelay;
    logic [1:0]  pcSrc;
    logic [31:0] extImm;
    logic [31:0] expPc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } sbEntry_t;

  vec_t     vecs[8];
  sbEntry_t sbQ[$];
  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait for a fetch request
  task automatic waitReq();
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Serve one fetch with the given number of wait cycles, then check the issued instruction
  task automatic doFetch(input logic [31:0] word, input int waits, input logic [31:0] expAddr);
    sbEntry_t e;
    waitReq();
    for (int w = 0; w < waits; w++) begin
      chk("addr_stable", imem_addr, expAddr);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      imem_ack = 1'b0;
      tick();
    end
    chk("fetch_addr", imem_addr, expAddr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    sbQ.push_back('{instr: word, addr: expAddr});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("req_low_issue", {31'd0, imem_req}, 32'd0);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      chk("instr", instr, e.instr);
      chk("pc_at_issue", pc, e.addr);
    end else begin
      chk("sb_empty", 32'd0, 32'd1);
    end
  endtask

  // Hold ISSUE for some cycles with junk controls, then handshake
  task automatic doIssue(input int delay, input logic wre, input logic [1:0] src,
                         input logic [31:0] imm, input logic [31:0] expPc);
    logic [31:0] pcHeld;
    pcHeld = pc;
    for (int d = 0; d < delay; d++) begin
      instr_ready = 1'b0;
      PCWre  = 1'b0;
      PCSrc  = 2'b10;
      ExtImm = 32'h1234_5678;
      tick();
      chk("issue_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("issue_hold_pc", pc, pcHeld);
    end
    instr_ready = 1'b1;
    PCWre  = wre;
    PCSrc  = src;
    ExtImm = imm;
    tick();
    instr_ready = 1'b0;
    PCWre  = 1'b1;
    PCSrc  = 2'b00;
    ExtImm = 32'h0;
    chk("next_pc", pc, expPc);
  endtask

  initial begin
    logic [31:0] addr;
    vecs[0] = '{32'h0400_0005, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0000_1111, 3, 0, 2'b00, 32'h0000_0000, 32'h0000_0008};
    vecs[2] = '{32'h1111_1111, 0, 2, 2'b01, 32'hFFFF_FFFE, 32'h0000_0004};
    vecs[3] = '{32'h2222_2222, 0, 0, 2'b11, 32'h0000_0000, 32'h0000_0008};
    vecs[4] = '{32'h3333_3333, 1, 0, 2'b01, 32'h0000_0003, 32'h0000_0018};
    vecs[5] = '{32'h4444_4444, 0, 0, 2'b01, 32'h03FF_FFFD, 32'h1000_0010};
    vecs[6] = '{32'hE000_0040, 0, 1, 2'b10, 32'h0000_0000, 32'h1000_0100};
    vecs[7] = '{32'h5555_5555, 0, 0, 2'b01, 32'hFBFF_FFC2, 32'h0000_000C};

    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);

    Reset = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);

    addr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      doFetch(vecs[i].rdata, vecs[i].waits, addr);
`ifdef FETCH_PERF_CNT_EN
      if (i == 1) chk("stall_cnt", stall_cnt, 32'd3);
`endif
      doIssue(vecs[i].readyDelay, 1'b1, vecs[i].pcSrc, vecs[i].extImm, vecs[i].expPc);
      addr = vecs[i].expPc;
    end

    // Halt at pc 12, branch select must be ignored
    doFetch(32'h6666_6666, 0, 32'h0000_000C);
    doIssue(0, 1'b0, 2'b01, 32'h0000_0010, 32'h0000_000C);
    chk("halted", {31'd0, halted}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_0000;
      chk("halt_no_req", {31'd0, imem_req}, 32'd0);
      chk("halt_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h0000_000C);
      chk("halt_stay", {31'd0, halted}, 32'd1);
      tick();
    end
    imem_ack = 1'b0;
    chk("halt_instr_kept", instr, 32'h6666_6666);
`ifdef FETCH_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, 32'd9);
`endif

    Reset = 1'b0;
    #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    Reset = 1'b1;

    // Reset lands in the same cycle as an ack in FETCH
    waitReq();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_valid_async", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    Reset    = 1'b1;
    doFetch(32'h0800_0001, 0, 32'h0);
    doIssue(0, 1'b1, 2'b00, 32'h0, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
